capture_trigger_writer: RTL and testbench

Upstream feeder for the IQ capture buffer. Watches a streaming I/Q sample input and, once armed, waits for a magnitude trigger or a forced trigger. It then writes exactly BUFFER_LENGTH consecutive samples into the capture buffer over its write address/data/response handshake. A small elastic FIFO absorbs capture-buffer backpressure; sample loss is flagged, never silent.

---
 rtl/capture_trigger_writer_pkg.sv | 32 +++
 rtl/capture_trigger_writer_if.sv | 27 ++
 rtl/capture_trigger_writer_fifo.sv | 70 +++++++
 rtl/capture_trigger_writer.sv | 178 +++++++++++++++++
 tb/tb_capture_trigger_writer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/capture_trigger_writer_pkg.sv
// Shared definitions for the IQ capture path.
// Provides the trigger magnitude width rule, the capture FSM state encodings
// and the {I,Q} packing helper that the capture buffer also uses.
package capture_trigger_writer_pkg;

  // FSM state encodings
  localparam int unsigned STATE_BITS = 3;
  localparam logic [STATE_BITS-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_BITS-1:0] ST_ARMED   = 3'd1;
  localparam logic [STATE_BITS-1:0] ST_CAPTURE = 3'd2;
  localparam logic [STATE_BITS-1:0] ST_DRAIN   = 3'd3;
  localparam logic [STATE_BITS-1:0] ST_DONE    = 3'd4;

  // Widest sample pair the packing helper can carry
  localparam int unsigned PACK_MAX = 64;

  // |I|+|Q| needs one bit more than the wider component
  function automatic int unsigned mag_bits(input int unsigned i_bits,
                                           input int unsigned q_bits);
    return ((i_bits > q_bits) ? i_bits : q_bits) + 1;
  endfunction

  // {I,Q} with I in the upper bits; caller truncates to I_BITS+Q_BITS
  function automatic logic [PACK_MAX-1:0] pack_iq(input logic [PACK_MAX-1:0] i_val,
                                                  input logic [PACK_MAX-1:0] q_val,
                                                  input int unsigned         q_bits);
    logic [PACK_MAX-1:0] q_mask;
    q_mask = (PACK_MAX'(1) << q_bits) - PACK_MAX'(1);
    return (i_val << q_bits) | (q_val & q_mask);
  endfunction

endpackage

// File: rtl/capture_trigger_writer_if.sv
// Capture-buffer write channel: address/data beat handshake plus write response.
//   m_axi_cap_waddr  : beat address          m_axi_cap_wdata : {I,Q} payload
//   m_axi_cap_wvalid : beat valid            s_axi_cap_wready: buffer accepts beat
//   s_axi_cap_bresp  : 1 = write error       s_axi_cap_bvalid: response valid
//   m_axi_cap_bready : response accept
interface capture_trigger_writer_if #(
  parameter int unsigned INDEX_BITS = 10,
  parameter int unsigned DATA_BITS  = 24
);
  logic [INDEX_BITS-1:0] m_axi_cap_waddr;
  logic [DATA_BITS-1:0]  m_axi_cap_wdata;
  logic                  m_axi_cap_wvalid;
  logic                  s_axi_cap_wready;
  logic                  s_axi_cap_bresp;
  logic                  s_axi_cap_bvalid;
  logic                  m_axi_cap_bready;

  modport master (
    output m_axi_cap_waddr, m_axi_cap_wdata, m_axi_cap_wvalid, m_axi_cap_bready,
    input  s_axi_cap_wready, s_axi_cap_bresp, s_axi_cap_bvalid
  );

  modport slave (
    input  m_axi_cap_waddr, m_axi_cap_wdata, m_axi_cap_wvalid, m_axi_cap_bready,
    output s_axi_cap_wready, s_axi_cap_bresp, s_axi_cap_bvalid
  );
endinterface

// File: rtl/capture_trigger_writer_fifo.sv
// Elastic FIFO between sample capture and capture-buffer writes.
// Ports: i_push/i_data write side, i_pop read side, o_head_c is the current
// head entry (mux of registered storage), o_full/o_empty registered flags.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module capture_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_c,
  output logic             o_full,
  output logic             o_empty
);
  localparam int unsigned PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_BITS = PTR_BITS + 1;

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [PTR_BITS-1:0] r_wr_ptr;
  logic [PTR_BITS-1:0] r_rd_ptr;
  logic [CNT_BITS-1:0] r_count;
  logic [CNT_BITS-1:0] w_count_nxt;
  logic                r_full;
  logic                r_empty;
  logic                w_do_push;
  logic                w_do_pop;

  assign w_do_pop  = i_pop && !r_empty;
  assign w_do_push = i_push && (!r_full || w_do_pop);

  // Occupancy after this cycle's push/pop
  always_comb begin
    w_count_nxt = r_count;
    if (w_do_push && !w_do_pop) begin
      w_count_nxt = r_count + CNT_BITS'(1);
    end else if (w_do_pop && !w_do_push) begin
      w_count_nxt = r_count - CNT_BITS'(1);
    end
  end

  // Pointers, count and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_BITS'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_BITS'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_BITS'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Storage; stale entries are never visible because reads are gated by empty
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head_c = r_mem[r_rd_ptr];
  assign o_full   = r_full;
  assign o_empty  = r_empty;

endmodule

// File: rtl/capture_trigger_writer.sv
// Trigger-and-capture feeder for the IQ capture buffer.
// Once armed, waits for |I|+|Q| >= threshold (or force_trig) on a valid sample,
// then writes BUFFER_LENGTH consecutive samples through an elastic FIFO.
// Ports: clk, rst_n (async, active-low); s_i/s_q/s_valid sample stream;
// arm, force_trig, threshold control; cap = capture-buffer write channel
// (master); busy, done, overflow, wr_err status.
module capture_trigger_writer
  import capture_trigger_writer_pkg::*;
#(
  parameter  int unsigned I_BITS        = 12,
  parameter  int unsigned Q_BITS        = 12,
  parameter  int unsigned INDEX_BITS    = 10,
  parameter  int unsigned BUFFER_LENGTH = 1000,
  parameter  int unsigned FIFO_DEPTH    = 4,
  localparam int unsigned MAG_BITS      = mag_bits(I_BITS, Q_BITS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [I_BITS-1:0] s_i,
  input  logic signed [Q_BITS-1:0] s_q,
  input  logic                     s_valid,
  input  logic                     arm,
  input  logic                     force_trig,
  input  logic [MAG_BITS-1:0]      threshold,
  capture_trigger_writer_if.master cap,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output logic                     wr_err
);
  localparam int unsigned DATA_BITS  = I_BITS + Q_BITS;
  localparam int unsigned ENTRY_BITS = INDEX_BITS + DATA_BITS;
  localparam int unsigned CNT_BITS   = $clog2(BUFFER_LENGTH + 1);
  localparam int unsigned SUM_BITS   = CNT_BITS + 1;

  logic [STATE_BITS-1:0] r_state;
  logic [STATE_BITS-1:0] w_state_nxt;

  logic                r_busy;
  logic                r_done;
  logic                r_bready;
  logic                r_overflow;
  logic                r_wr_err;
  logic [CNT_BITS-1:0] r_push_cnt;
  logic [CNT_BITS-1:0] r_beat_cnt;
  logic [CNT_BITS-1:0] r_resp_cnt;
  logic [CNT_BITS-1:0] r_drop_cnt;

  logic signed [MAG_BITS-1:0] w_i_ext;
  logic signed [MAG_BITS-1:0] w_q_ext;
  logic [MAG_BITS-1:0]        w_abs_i;
  logic [MAG_BITS-1:0]        w_abs_q;
  logic [MAG_BITS-1:0]        w_mag;

  logic                  w_arm_ok;
  logic                  w_trig;
  logic                  w_cap_push;
  logic                  w_take;
  logic                  w_pop;
  logic                  w_drop;
  logic                  w_resp;
  logic                  w_push_done;
  logic                  w_drain_done;
  logic [DATA_BITS-1:0]  w_iq;
  logic [ENTRY_BITS-1:0] w_fifo_in;
  logic [ENTRY_BITS-1:0] w_fifo_head;
  logic [INDEX_BITS-1:0] w_head_addr;
  logic [DATA_BITS-1:0]  w_head_data;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;

  // Magnitude: one extra bit makes |most-negative| representable
  assign w_i_ext = {{(MAG_BITS-I_BITS){s_i[I_BITS-1]}}, s_i};
  assign w_q_ext = {{(MAG_BITS-Q_BITS){s_q[Q_BITS-1]}}, s_q};
  assign w_abs_i = w_i_ext[MAG_BITS-1] ? MAG_BITS'(-w_i_ext) : MAG_BITS'(w_i_ext);
  assign w_abs_q = w_q_ext[MAG_BITS-1] ? MAG_BITS'(-w_q_ext) : MAG_BITS'(w_q_ext);
  assign w_mag   = w_abs_i + w_abs_q;

  // Session events
  assign w_arm_ok   = arm && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_trig     = (r_state == ST_ARMED) && s_valid && (force_trig || (w_mag >= threshold));
  assign w_cap_push = (r_state == ST_CAPTURE) && s_valid && (r_push_cnt < CNT_BITS'(BUFFER_LENGTH));
  assign w_take     = w_trig || w_cap_push;
  assign w_pop      = !w_fifo_empty && cap.s_axi_cap_wready;
  assign w_drop     = w_cap_push && w_fifo_full && !w_pop;
  assign w_resp     = cap.s_axi_cap_bvalid && r_bready;

  // Dropped samples never produce a beat or response, so they count toward completion
  assign w_push_done  = (r_push_cnt == CNT_BITS'(BUFFER_LENGTH));
  assign w_drain_done = ((SUM_BITS'(r_beat_cnt) + SUM_BITS'(r_drop_cnt)) == SUM_BITS'(BUFFER_LENGTH))
                     && ((SUM_BITS'(r_resp_cnt) + SUM_BITS'(r_drop_cnt)) == SUM_BITS'(BUFFER_LENGTH));

  // Each entry carries its sample-time address so drop holes are skipped, not back-filled
  assign w_iq      = DATA_BITS'(pack_iq(PACK_MAX'(s_i), PACK_MAX'(s_q), Q_BITS));
  assign w_fifo_in = {INDEX_BITS'(r_push_cnt), w_iq};

  capture_fifo #(
    .WIDTH (ENTRY_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_push   (w_take && !w_drop),
    .i_data   (w_fifo_in),
    .i_pop    (w_pop),
    .o_head_c (w_fifo_head),
    .o_full   (w_fifo_full),
    .o_empty  (w_fifo_empty)
  );

  assign {w_head_addr, w_head_data} = w_fifo_head;

  // Write channel is driven straight from FIFO registers; zero while empty
  assign cap.m_axi_cap_wvalid = !w_fifo_empty;
  assign cap.m_axi_cap_waddr  = w_fifo_empty ? '0 : w_head_addr;
  assign cap.m_axi_cap_wdata  = w_fifo_empty ? '0 : w_head_data;
  assign cap.m_axi_cap_bready = r_bready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (arm)          w_state_nxt = ST_ARMED;
      ST_ARMED:   if (w_trig)       w_state_nxt = ST_CAPTURE;
      ST_CAPTURE: if (w_push_done)  w_state_nxt = ST_DRAIN;
      ST_DRAIN:   if (w_drain_done) w_state_nxt = ST_DONE;
      ST_DONE:    if (arm)          w_state_nxt = ST_ARMED;
      default:                      w_state_nxt = ST_IDLE;
    endcase
  end

  // Status flags and session counters; arm starts a clean session
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bready   <= 1'b0;
      r_overflow <= 1'b0;
      r_wr_err   <= 1'b0;
      r_push_cnt <= '0;
      r_beat_cnt <= '0;
      r_resp_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_busy   <= (w_state_nxt == ST_ARMED) || (w_state_nxt == ST_CAPTURE)
               || (w_state_nxt == ST_DRAIN);
      r_done   <= (w_state_nxt == ST_DONE);
      r_bready <= (w_state_nxt == ST_CAPTURE) || (w_state_nxt == ST_DRAIN);
      if (w_arm_ok) begin
        r_overflow <= 1'b0;
        r_wr_err   <= 1'b0;
        r_push_cnt <= '0;
        r_beat_cnt <= '0;
        r_resp_cnt <= '0;
        r_drop_cnt <= '0;
      end else begin
        if (w_drop)                             r_overflow <= 1'b1;
        if (w_resp && cap.s_axi_cap_bresp)      r_wr_err   <= 1'b1;
        if (w_take)                             r_push_cnt <= r_push_cnt + CNT_BITS'(1);
        if (w_pop)                              r_beat_cnt <= r_beat_cnt + CNT_BITS'(1);
        if (w_resp)                             r_resp_cnt <= r_resp_cnt + CNT_BITS'(1);
        if (w_drop)                             r_drop_cnt <= r_drop_cnt + CNT_BITS'(1);
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_overflow;
  assign wr_err   = r_wr_err;

endmodule

// File: tb/tb_capture_trigger_writer.sv
// Directed bench for capture_trigger_writer with an 8-sample capture and 4-deep FIFO.
module tb_capture_trigger_writer;
  localparam int unsigned I_BITS     = 12;
  localparam int unsigned Q_BITS     = 12;
  localparam int unsigned INDEX_BITS = 10;
  localparam int unsigned BL         = 8;
  localparam int unsigned FD         = 4;
  localparam int unsigned DATA_BITS  = I_BITS + Q_BITS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic signed [I_BITS-1:0] s_i;
  logic signed [Q_BITS-1:0] s_q;
  logic        s_valid;
  logic        arm;
  logic        force_trig;
  logic [12:0] threshold;
  logic        busy;
  logic        done;
  logic        overflow;
  logic        wr_err;

  capture_trigger_writer_if #(.INDEX_BITS(INDEX_BITS), .DATA_BITS(DATA_BITS)) cap_if ();

  capture_trigger_writer #(
    .I_BITS        (I_BITS),
    .Q_BITS        (Q_BITS),
    .INDEX_BITS    (INDEX_BITS),
    .BUFFER_LENGTH (BL),
    .FIFO_DEPTH    (FD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_i        (s_i),
    .s_q        (s_q),
    .s_valid    (s_valid),
    .arm        (arm),
    .force_trig (force_trig),
    .threshold  (threshold),
    .cap        (cap_if),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .wr_err     (wr_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int err_idx = -1;
  int resp_idx = 0;
  int pend = 0;
  logic [INDEX_BITS-1:0] log_addr[$];
  logic [DATA_BITS-1:0]  log_data[$];

  // Capture-buffer model: logs accepted beats, answers each one a cycle or more later
  initial begin
    cap_if.s_axi_cap_bvalid = 1'b0;
    cap_if.s_axi_cap_bresp  = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        pend = 0;
        cap_if.s_axi_cap_bvalid = 1'b0;
        cap_if.s_axi_cap_bresp  = 1'b0;
      end else begin
        if (pend > 0 && cap_if.m_axi_cap_bready) begin
          cap_if.s_axi_cap_bvalid = 1'b1;
          cap_if.s_axi_cap_bresp  = (resp_idx == err_idx);
          pend--;
          resp_idx++;
        end else begin
          cap_if.s_axi_cap_bvalid = 1'b0;
          cap_if.s_axi_cap_bresp  = 1'b0;
        end
        if (cap_if.m_axi_cap_wvalid && cap_if.s_axi_cap_wready) begin
          pend++;
          log_addr.push_back(cap_if.m_axi_cap_waddr);
          log_data.push_back(cap_if.m_axi_cap_wdata);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  // One clock of stimulus, entered and left on a falling edge
  task automatic step(input int i, input int q, input logic v, input logic f, input logic a);
    s_i = 12'(i);
    s_q = 12'(q);
    s_valid = v;
    force_trig = f;
    arm = a;
    @(negedge clk);
    s_valid = 1'b0;
    force_trig = 1'b0;
    arm = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  function automatic logic [DATA_BITS-1:0] iq(input int i, input int q);
    logic [11:0] ei;
    logic [11:0] eq;
    ei = 12'(i);
    eq = 12'(q);
    return {ei, eq};
  endfunction

  task automatic test_reset();
    s_i = '0; s_q = '0; s_valid = 1'b0; arm = 1'b0; force_trig = 1'b0;
    threshold = '0;
    cap_if.s_axi_cap_wready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({cap_if.m_axi_cap_wvalid, cap_if.m_axi_cap_bready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_handshake: got wvalid/bready %b%b want 00",
                         cap_if.m_axi_cap_wvalid, cap_if.m_axi_cap_bready);
    end
    n_tests++;
    if ({cap_if.m_axi_cap_waddr, cap_if.m_axi_cap_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_bus: got addr %0h data %0h want 0",
                         cap_if.m_axi_cap_waddr, cap_if.m_axi_cap_wdata);
    end
    n_tests++;
    if ({busy, done, overflow, wr_err} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_status: got %b want 0000", {busy, done, overflow, wr_err});
    end
    rst_n = 1'b1;
    step(5, 5, 1'b1, 1'b1, 1'b0);
    n_tests++;
    if ({busy, cap_if.m_axi_cap_wvalid} !== 2'b00) begin
      n_fail++; $display("FAIL idle_ignores_samples: got busy/wvalid %b%b want 00",
                         busy, cap_if.m_axi_cap_wvalid);
    end
  endtask

  task automatic test_force_capture();
    int base;
    bit ok;
    base = log_addr.size();
    err_idx = -1;
    cap_if.s_axi_cap_wready = 1'b1;
    step(0, 0, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL force_armed_busy: got %b want 1", busy);
    end
    for (int k = 0; k < 8; k++) step(k, -k, 1'b1, (k == 0), 1'b0);
    step(99, 99, 1'b1, 1'b0, 1'b0);
    step(99, 99, 1'b1, 1'b0, 1'b0);
    wait_done(60, ok);
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL force_done_timeout: got done=%b want 1", done);
    end
    n_tests++;
    if (log_addr.size() - base != 8) begin
      n_fail++; $display("FAIL force_beat_count: got %0d want 8", log_addr.size() - base);
    end
    for (int k = 0; k < 8; k++) begin
      n_tests++;
      if (log_addr[base+k] !== 10'(k) || log_data[base+k] !== iq(k, -k)) begin
        n_fail++; $display("FAIL force_beat%0d: got addr %0d data %h want addr %0d data %h",
                           k, log_addr[base+k], log_data[base+k], k, iq(k, -k));
      end
    end
    n_tests++;
    if ({busy, overflow, wr_err, cap_if.m_axi_cap_bready} !== 4'b0000) begin
      n_fail++; $display("FAIL force_final_flags: got busy/ovf/err/bready %b want 0000",
                         {busy, overflow, wr_err, cap_if.m_axi_cap_bready});
    end
  endtask

  task automatic test_threshold();
    int base;
    bit ok;
    base = log_addr.size();
    threshold = 13'd100;
    step(0, 0, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL arm_clears_done: got %b want 0", done);
    end
    step(0, 0, 1'b0, 1'b1, 1'b0);
    step(30, -20, 1'b1, 1'b0, 1'b0);
    step(99, 0, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if ({busy, cap_if.m_axi_cap_wvalid} !== 2'b10) begin
      n_fail++; $display("FAIL thr_below_no_trigger: got busy/wvalid %b%b want 10",
                         busy, cap_if.m_axi_cap_wvalid);
    end
    step(-60, 40, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (cap_if.m_axi_cap_wvalid !== 1'b1) begin
      n_fail++; $display("FAIL thr_trigger_wvalid: got %b want 1", cap_if.m_axi_cap_wvalid);
    end
    step(120, 0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k < 7; k++) step(k, k, 1'b1, 1'b0, 1'b0);
    wait_done(60, ok);
    n_tests++;
    if (!ok || log_addr.size() - base != 8) begin
      n_fail++; $display("FAIL thr_complete: got done=%b beats=%0d want 1 and 8",
                         done, log_addr.size() - base);
    end
    n_tests++;
    if (log_addr[base] !== 10'd0 || log_data[base] !== iq(-60, 40)) begin
      n_fail++; $display("FAIL thr_first_beat: got addr %0d data %h want 0 %h",
                         log_addr[base], log_data[base], iq(-60, 40));
    end
    n_tests++;
    if (log_addr[base+1] !== 10'd1 || log_data[base+1] !== iq(120, 0)) begin
      n_fail++; $display("FAIL thr_second_beat: got addr %0d data %h want 1 %h",
                         log_addr[base+1], log_data[base+1], iq(120, 0));
    end
  endtask

  task automatic test_most_negative();
    int base;
    bit ok;
    base = log_addr.size();
    threshold = 13'd4096;
    step(0, 0, 1'b0, 1'b0, 1'b1);
    step(2047, 2047, 1'b1, 1'b0, 1'b0);
    step(-2048, 2047, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (cap_if.m_axi_cap_wvalid !== 1'b0) begin
      n_fail++; $display("FAIL mag4095_no_trigger: got wvalid %b want 0", cap_if.m_axi_cap_wvalid);
    end
    step(-2048, -2048, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) step(0, 0, 1'b1, 1'b0, 1'b0);
    wait_done(60, ok);
    n_tests++;
    if (!ok || log_addr.size() - base != 8) begin
      n_fail++; $display("FAIL mag4096_complete: got done=%b beats=%0d want 1 and 8",
                         done, log_addr.size() - base);
    end
    n_tests++;
    if (log_addr[base] !== 10'd0 || log_data[base] !== 24'h800800) begin
      n_fail++; $display("FAIL mag4096_first_beat: got addr %0d data %h want 0 800800",
                         log_addr[base], log_data[base]);
    end
  endtask

  task automatic test_overflow();
    int base;
    bit ok;
    int exp_k[6];
    exp_k = '{0, 1, 2, 3, 6, 7};
    base = log_addr.size();
    threshold = 13'd8191;
    cap_if.s_axi_cap_wready = 1'b0;
    step(0, 0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      step(k, -k, 1'b1, (k == 0), 1'b0);
      if (k == 3) begin
        n_tests++;
        if (overflow !== 1'b0) begin
          n_fail++; $display("FAIL ovf_full_no_drop: got %b want 0", overflow);
        end
      end
    end
    n_tests++;
    if (overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow);
    end
    cap_if.s_axi_cap_wready = 1'b1;
    step(6, -6, 1'b1, 1'b0, 1'b0);
    step(7, -7, 1'b1, 1'b0, 1'b0);
    wait_done(60, ok);
    n_tests++;
    if (!ok || log_addr.size() - base != 6) begin
      n_fail++; $display("FAIL ovf_complete: got done=%b beats=%0d want 1 and 6",
                         done, log_addr.size() - base);
    end
    for (int j = 0; j < 6; j++) begin
      n_tests++;
      if (log_addr[base+j] !== 10'(exp_k[j]) || log_data[base+j] !== iq(exp_k[j], -exp_k[j])) begin
        n_fail++; $display("FAIL ovf_beat%0d: got addr %0d data %h want addr %0d data %h",
                           j, log_addr[base+j], log_data[base+j], exp_k[j], iq(exp_k[j], -exp_k[j]));
      end
    end
    n_tests++;
    if (overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow);
    end
  endtask

  task automatic test_wr_err();
    int base;
    bit ok;
    base = log_addr.size();
    cap_if.s_axi_cap_wready = 1'b1;
    step(0, 0, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if ({overflow, wr_err} !== 2'b00) begin
      n_fail++; $display("FAIL arm_clears_flags: got ovf/err %b%b want 00", overflow, wr_err);
    end
    err_idx = resp_idx + 2;
    for (int k = 0; k < 8; k++) step(k + 20, k, 1'b1, (k == 0), (k == 3));
    wait_done(60, ok);
    n_tests++;
    if (!ok || wr_err !== 1'b1) begin
      n_fail++; $display("FAIL wrerr_done: got done=%b wr_err=%b want 1 1", done, wr_err);
    end
    n_tests++;
    if (log_addr.size() - base != 8 || log_addr[base+7] !== 10'd7 ||
        log_data[base+7] !== iq(27, 7)) begin
      n_fail++; $display("FAIL wrerr_beats: got beats=%0d last addr %0d data %h want 8 7 %h",
                         log_addr.size() - base, log_addr[base+7], log_data[base+7], iq(27, 7));
    end
    err_idx = -1;
  endtask

  task automatic test_abort_restart();
    int base;
    bit ok;
    cap_if.s_axi_cap_wready = 1'b1;
    step(0, 0, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if ({done, wr_err} !== 2'b00) begin
      n_fail++; $display("FAIL rearm_clears: got done/err %b%b want 00", done, wr_err);
    end
    for (int k = 0; k < 5; k++) step(k, k, 1'b1, (k == 0), 1'b0);
    n_tests++;
    if (cap_if.m_axi_cap_wvalid !== 1'b1) begin
      n_fail++; $display("FAIL abort_precond_wvalid: got %b want 1", cap_if.m_axi_cap_wvalid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({cap_if.m_axi_cap_wvalid, cap_if.m_axi_cap_bready, busy, done, overflow, wr_err} !== 6'b0 ||
        {cap_if.m_axi_cap_waddr, cap_if.m_axi_cap_wdata} !== '0) begin
      n_fail++; $display("FAIL abort_outputs: got wv/br/busy/done/ovf/err %b addr %0d data %h want all 0",
                         {cap_if.m_axi_cap_wvalid, cap_if.m_axi_cap_bready, busy, done, overflow, wr_err},
                         cap_if.m_axi_cap_waddr, cap_if.m_axi_cap_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    base = log_addr.size();
    step(0, 0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) step(k + 10, -(k + 10), 1'b1, (k == 0), 1'b0);
    wait_done(60, ok);
    n_tests++;
    if (!ok || log_addr.size() - base != 8) begin
      n_fail++; $display("FAIL restart_complete: got done=%b beats=%0d want 1 and 8",
                         done, log_addr.size() - base);
    end
    n_tests++;
    if (log_addr[base] !== 10'd0 || log_data[base] !== iq(10, -10) ||
        log_addr[base+7] !== 10'd7) begin
      n_fail++; $display("FAIL restart_addr: got first %0d data %h last %0d want 0 %h 7",
                         log_addr[base], log_data[base], log_addr[base+7], iq(10, -10));
    end
    n_tests++;
    if ({overflow, wr_err} !== 2'b00) begin
      n_fail++; $display("FAIL restart_flags: got ovf/err %b%b want 00", overflow, wr_err);
    end
  endtask

  initial begin
    test_reset();
    test_force_capture();
    test_threshold();
    test_most_negative();
    test_overflow();
    test_wr_err();
    test_abort_restart();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
